// File: rtl/decode_mask32_pkg.sv
// Shared constants, types and helpers for the decode_mask32 occupancy tracker.
//   IDX_W  : width of a bit index into the mask
//   MASK_W : number of tracked slots
//   CNT_W  : width of the population count (must hold 0..MASK_W)
//   popcount32() : constant-foldable population count, used for the reset count
package decode_mask32_pkg;

    localparam int IDX_W  = 5;
    localparam int MASK_W = 32;
    localparam int CNT_W  = 6;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [MASK_W-1:0] mask_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'(MASK_W);

    function automatic cnt_t popcount32(input mask_t m);
        cnt_t acc;
        acc = '0;
        for (int i = 0; i < MASK_W; i++) begin
            acc = acc + cnt_t'(m[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/decode_mask32_if.sv
// Request/response bundle for decode_mask32.
//   Requests : set_v/set_idx, clr_v/clr_idx, q_v/q_idx, err_clr
//   Status   : mask, cnt, full, empty, q_rv, q_hit, err_dset, err_dclr
// master = requester side (drives requests), slave = the tracker itself.
interface decode_mask32_if;
    import decode_mask32_pkg::*;

    logic  set_v;
    idx_t  set_idx;
    logic  clr_v;
    idx_t  clr_idx;
    logic  q_v;
    idx_t  q_idx;
    logic  err_clr;

    mask_t mask;
    cnt_t  cnt;
    logic  full;
    logic  empty;
    logic  q_rv;
    logic  q_hit;
    logic  err_dset;
    logic  err_dclr;

    modport master (
        output set_v, set_idx, clr_v, clr_idx, q_v, q_idx, err_clr,
        input  mask, cnt, full, empty, q_rv, q_hit, err_dset, err_dclr
    );

    modport slave (
        input  set_v, set_idx, clr_v, clr_idx, q_v, q_idx, err_clr,
        output mask, cnt, full, empty, q_rv, q_hit, err_dset, err_dclr
    );

endinterface

// File: rtl/decode_mask32_dec.sv
// dec5_32 : combinational 5-to-32 one-hot decoder with enable.
//   en     : when low the output is all zeros
//   idx    : bit position to assert
//   onehot : one-hot result
module dec5_32
    import decode_mask32_pkg::*;
(
    input  logic  en,
    input  idx_t  idx,
    output mask_t onehot
);

    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_bit
        assign onehot[gi] = en && (idx == idx_t'(gi));
    end

endmodule

// File: rtl/decode_mask32.sv
// decode_mask32 : 32-slot occupancy mask with incremental population count,
// latency-1 bit query and sticky double-set / double-clear error flags.
//   clk, rst : clock and synchronous active-high reset
//   bus      : decode_mask32_if.slave (requests in, status out)
//   INIT_MASK: mask value loaded on reset
module decode_mask32
    import decode_mask32_pkg::*;
#(
    parameter mask_t INIT_MASK = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_mask32_if.slave        bus
);

    localparam cnt_t INIT_CNT = popcount32(INIT_MASK);

    mask_t mask_reg, mask_next;
    cnt_t  cnt_reg, cnt_next;
    logic  q_rv_reg, q_hit_reg;
    logic  err_dset_reg, err_dset_next;
    logic  err_dclr_reg, err_dclr_next;

    mask_t set_onehot;
    mask_t clr_onehot;

    dec5_32 u_dec_set (
        .en     (bus.set_v),
        .idx    (bus.set_idx),
        .onehot (set_onehot)
    );

    dec5_32 u_dec_clr (
        .en     (bus.clr_v),
        .idx    (bus.clr_idx),
        .onehot (clr_onehot)
    );

    logic same_idx;
    logic set_eff;   // set actually flips a 0 to 1
    logic clr_eff;   // clear actually flips a 1 to 0 (set on same index wins)
    logic dset_hit;
    logic dclr_hit;

    always_comb begin
        same_idx = bus.set_v && bus.clr_v && (bus.set_idx == bus.clr_idx);
        set_eff  = bus.set_v && !mask_reg[bus.set_idx];
        clr_eff  = bus.clr_v && mask_reg[bus.clr_idx] && !same_idx;
        dset_hit = bus.set_v && mask_reg[bus.set_idx] && !same_idx;
        dclr_hit = bus.clr_v && !mask_reg[bus.clr_idx];

        // Ordering of AND-clear then OR-set is what makes set win on a tie.
        mask_next = (mask_reg & ~clr_onehot) | set_onehot;

        // Set and clear on different live bits cancel; saturate at both ends.
        cnt_next = cnt_reg;
        if (set_eff && !clr_eff && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + cnt_t'(1);
        end else if (clr_eff && !set_eff && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - cnt_t'(1);
        end

        // A fresh error in the err_clr cycle keeps the flag asserted.
        err_dset_next = (err_dset_reg && !bus.err_clr) || dset_hit;
        err_dclr_next = (err_dclr_reg && !bus.err_clr) || dclr_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg     <= INIT_MASK;
            cnt_reg      <= INIT_CNT;
            q_rv_reg     <= 1'b0;
            q_hit_reg    <= 1'b0;
            err_dset_reg <= 1'b0;
            err_dclr_reg <= 1'b0;
        end else begin
            mask_reg     <= mask_next;
            cnt_reg      <= cnt_next;
            q_rv_reg     <= bus.q_v;
            // Query observes the mask as it stood before this edge's update.
            q_hit_reg    <= bus.q_v && mask_reg[bus.q_idx];
            err_dset_reg <= err_dset_next;
            err_dclr_reg <= err_dclr_next;
        end
    end

    assign bus.mask     = mask_reg;
    assign bus.cnt      = cnt_reg;
    assign bus.full     = (cnt_reg == CNT_MAX);
    assign bus.empty    = (cnt_reg == '0);
    assign bus.q_rv     = q_rv_reg;
    assign bus.q_hit    = q_hit_reg;
    assign bus.err_dset = err_dset_reg;
    assign bus.err_dclr = err_dclr_reg;

endmodule

// File: doc/decode_mask32.md
DECODE_MASK32 -- requirements
Module: decode_mask32

Interface
REQ-001 INIT_MASK, 32'h0000_0000, reset value of the 32-bit occupancy mask.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 set_v  input  1  set request valid.
REQ-005 set_idx  input  5  index of the mask bit to set.
REQ-006 clr_v  input  1  clear request valid.
REQ-007 clr_idx  input  5  index of the mask bit to clear.
REQ-008 q_v  input  1  query request valid.
REQ-009 q_idx  input  5  index to query.
REQ-010 err_clr  input  1  clears sticky error flags.
REQ-011 mask  output  32  registered occupancy mask.
REQ-012 cnt  output  6  registered population count of mask, 0..32.
REQ-013 full  output  1  cnt == 32.
REQ-014 empty  output  1  cnt == 0.
REQ-015 q_rv  output  1  query response valid.
REQ-016 q_hit  output  1  query result, mask bit value.
REQ-017 err_dset  output  1  sticky double-set error.
REQ-018 err_dclr  output  1  sticky double-clear error.

Function
REQ-019 The block SHALL decode set_idx and clr_idx to one-hot 32-bit vectors and update mask on each rising edge: mask_next = (mask & ~clr_onehot) | set_onehot, with each one-hot forced to zero when its valid is low.
REQ-020 Set and clear of the same index in the same cycle SHALL leave that bit at 1 (set wins); set and clear of different indices SHALL both take effect.
REQ-021 cnt SHALL be registered alongside mask and always equal popcount(mask) in the same cycle; cnt_next = cnt + (set effective 0->1) - (clear effective 1->0), never wrapping past 0 or 32.
REQ-022 full and empty SHALL be combinational decodes of registered cnt only.
REQ-023 A query SHALL have latency 1: q_v sampled at edge N produces q_rv=1 for the cycle after edge N, q_hit = mask[q_idx] as held before edge N (pre-update value); q_rv=0 and q_hit=0 when no query was sampled.
REQ-024 Back-to-back queries SHALL be accepted every cycle with no stall.
REQ-025 err_dset SHALL set when set_v and mask[set_idx]=1 and not (clr_v and clr_idx==set_idx).
REQ-026 err_dclr SHALL set when clr_v and mask[clr_idx]=0.
REQ-027 Erroneous requests SHALL still apply per REQ-019 (idempotent on mask, cnt unchanged).
REQ-028 Error flags SHALL hold until err_clr or rst; a new error in the same cycle as err_clr SHALL win (flag stays 1).

Reset
REQ-029 With rst=1 at an edge: mask=INIT_MASK, cnt=popcount(INIT_MASK), q_rv=0, q_hit=0, err_dset=0, err_dclr=0; all requests in that cycle SHALL be ignored.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight query response.

Structure
REQ-031 Width constants (index width 5, mask width 32, count width 6) SHALL live in the shared include file used by the encoder blocks.
REQ-032 The 5-to-32 decode SHALL be a sub-module dec5_32 (combinational, with enable input), instantiated twice; state SHALL use the standard library flip-flop cells.

Verification
REQ-033 Reset with INIT_MASK=32'h0000_000F -> mask=0000_000F, cnt=4, empty=0, full=0, errors=0.
REQ-034 Set idx 0..31 in consecutive cycles from empty -> cnt increments by 1 per cycle, full=1 after 32nd edge, mask=FFFF_FFFF.
REQ-035 Same cycle set_idx=7, clr_idx=7 with mask[7]=1 -> mask[7]=1, cnt unchanged, err_dset=0; with mask[7]=0 -> mask[7]=1, cnt+1, err_dclr=1.
REQ-036 Query idx 12 in the same cycle as set idx 12 from empty -> next cycle q_rv=1, q_hit=0; repeat query -> q_hit=1.
REQ-037 Clear idx 3 on empty mask -> err_dclr=1, cnt=0; pulse err_clr -> err_dclr=0 next cycle.
REQ-038 Assert rst while q_v=1 and set_v=1 -> next cycle q_rv=0, mask=INIT_MASK.
